canxl_rx_crc_chk: RTL and testbench

Parametrised successor to the receive-side frame CRC accumulator. It serially accumulates a CRC over received bits, one bit per new bit-counter value. It then captures the transmitted CRC field and compares it against the accumulated value, flagging pass or fail. It sits in the CAN XL receive path beside the bit-stream decoder and feeds the error-handling and ACK logic.

---
 rtl/canxl_rx_crc_chk.sv | 127 ++++++++++++
 tb/tb_canxl_rx_crc_chk.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/canxl_rx_crc_chk.sv
// Receive-side CAN XL frame CRC checker: serially accumulates the CRC over
// the protected region, captures the transmitted CRC field and compares.
module canxl_rx_crc_chk #(
  parameter int          CRC_W = 32,
  parameter logic [31:0] POLY  = 32'h90BF6B5E,
  parameter logic [31:0] INIT  = 32'h0,
  parameter int          CNT_W = 15
) (
  input  logic             clk,
  input  logic             g_rst,
  input  logic             data,
  input  logic             crc_enable,
  input  logic             crc_field_en,
  input  logic             initialize,
  input  logic             tx_success,
  input  logic             rx_success,
  input  logic [CNT_W-1:0] rcvd_bt_cnt,
  output logic [CRC_W-1:0] crc_val,
  output logic [CRC_W-1:0] crc_rcvd,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             busy
);

  localparam int FC_W = $clog2(CRC_W + 1);
  localparam logic [CRC_W-1:0] POLY_C   = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C   = INIT[CRC_W-1:0];
  localparam logic [FC_W-1:0]  FLD_LAST = FC_W'(CRC_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] prev_cnt_q;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] rcvd_q, rcvd_d;
  logic [FC_W-1:0]  fld_q, fld_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             nb;
  logic             fb;

  // A new bit is any change of the received bit counter, wrap-around included.
  assign nb = (rcvd_bt_cnt != prev_cnt_q);
  assign fb = data ^ crc_q[CRC_W-1];

  // Next-state logic: success clears to IDLE, initialize clears to CALC,
  // otherwise the frame FSM runs.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    rcvd_d  = rcvd_q;
    fld_d   = fld_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;
    if (tx_success || rx_success || initialize) begin
      crc_d   = INIT_C;
      rcvd_d  = '0;
      fld_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      state_d = (tx_success || rx_success) ? IDLE : CALC;
    end else begin
      case (state_q)
        CALC: begin
          if (nb && crc_field_en) begin
            // Field bits are captured MSB first; the CRC stays frozen.
            rcvd_d = {rcvd_q[CRC_W-2:0], data};
            fld_d  = fld_q + 1'b1;
            if (fld_d == FLD_LAST) begin
              state_d = CMP;
            end
          end else if (nb && crc_enable) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : '0);
          end
        end
        CMP: begin
          done_d  = 1'b1;
          ok_d    = (rcvd_q == crc_q);
          err_d   = (rcvd_q != crc_q);
          state_d = DONE;
        end
        default: begin
          // IDLE and DONE hold everything until initialize or success.
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_q    <= IDLE;
      prev_cnt_q <= '0;
      crc_q      <= INIT_C;
      rcvd_q     <= '0;
      fld_q      <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_cnt_q <= rcvd_bt_cnt;
      crc_q      <= crc_d;
      rcvd_q     <= rcvd_d;
      fld_q      <= fld_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign crc_val  = crc_q;
  assign crc_rcvd = rcvd_q;
  assign crc_done = done_q;
  assign crc_ok   = ok_q;
  assign crc_err  = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_canxl_rx_crc_chk.sv
// Directed bench for canxl_rx_crc_chk: default 32-bit instance plus a
// 15-bit instance driven by the same stimulus.
module tb_canxl_rx_crc_chk;

  logic        clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        data = 1'b0;
  logic        crc_enable = 1'b0;
  logic        crc_field_en = 1'b0;
  logic        initialize = 1'b0;
  logic        tx_success = 1'b0;
  logic        rx_success = 1'b0;
  logic [14:0] cnt = '0;

  logic [31:0] crc_val, crc_rcvd;
  logic        crc_done, crc_ok, crc_err, busy;
  logic [14:0] s_crc_val, s_crc_rcvd;
  logic        s_crc_done, s_crc_ok, s_crc_err, s_busy;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  canxl_rx_crc_chk dut (
    .clk(clk), .g_rst(g_rst), .data(data), .crc_enable(crc_enable),
    .crc_field_en(crc_field_en), .initialize(initialize),
    .tx_success(tx_success), .rx_success(rx_success), .rcvd_bt_cnt(cnt),
    .crc_val(crc_val), .crc_rcvd(crc_rcvd), .crc_done(crc_done),
    .crc_ok(crc_ok), .crc_err(crc_err), .busy(busy)
  );

  canxl_rx_crc_chk #(.CRC_W(15), .POLY(32'h4599)) dut15 (
    .clk(clk), .g_rst(g_rst), .data(data), .crc_enable(crc_enable),
    .crc_field_en(crc_field_en), .initialize(initialize),
    .tx_success(tx_success), .rx_success(rx_success), .rcvd_bt_cnt(cnt),
    .crc_val(s_crc_val), .crc_rcvd(s_crc_rcvd), .crc_done(s_crc_done),
    .crc_ok(s_crc_ok), .crc_err(s_crc_err), .busy(s_busy)
  );

  // Count crc_done pulses away from the active edge.
  always @(negedge clk) if (crc_done) done_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic en, input logic fld);
    data = d; crc_enable = en; crc_field_en = fld;
    cnt = cnt + 15'd1;
    tick();
    crc_enable = 1'b0; crc_field_en = 1'b0;
  endtask

  task automatic do_init();
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
  endtask

  // Frame of data bits 1,0 followed by a 32-bit field; ends in the CMP cycle.
  task automatic run_frame(input logic [31:0] fld);
    do_init();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    for (int i = 31; i >= 0; i--) send_bit(fld[i], 1'b0, 1'b1);
  endtask

  int d0;
  logic [31:0] snap;

  initial begin
    // Reset state
    #1;
    chk("rst_crc_val", crc_val, 32'h0);
    chk("rst_flags", {28'd0, crc_done, crc_ok, crc_err, busy}, 32'h0);
    cnt = 15'h7FFF;
    tick(); tick();
    g_rst = 1'b0;
    tick();

    // Test 1: two data bits; first strobe is a counter wrap 7FFF->0
    do_init();
    chk("init_busy", {31'd0, busy}, 32'h1);
    send_bit(1'b1, 1'b1, 1'b0);
    chk("t1_bit1", crc_val, 32'h90BF6B5E);
    send_bit(1'b0, 1'b1, 1'b0);
    chk("t1_bit0", crc_val, 32'hB1C1BDE2);

    // Test 2: held counter never steps the CRC
    data = 1'b1; crc_enable = 1'b1;
    repeat (10) tick();
    crc_enable = 1'b0;
    chk("t2_hold", crc_val, 32'hB1C1BDE2);

    // nb with no enable: no change
    send_bit(1'b1, 1'b0, 1'b0);
    chk("noen_crc", crc_val, 32'hB1C1BDE2);

    // Test 3: matching CRC field
    d0 = done_pulses;
    run_frame(32'hB1C1BDE2);
    chk("t3_rcvd", crc_rcvd, 32'hB1C1BDE2);
    chk("t3_done_early", {31'd0, crc_ok}, 32'h0);
    repeat (3) tick();
    chk("t3_ok", {30'd0, crc_ok, crc_err}, 32'h2);
    chk("t3_pulses", done_pulses - d0, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'h1);
    send_bit(1'b1, 1'b1, 1'b1);
    chk("t3_ign_rcvd", crc_rcvd, 32'hB1C1BDE2);
    chk("t3_ign_val", crc_val, 32'hB1C1BDE2);
    repeat (2) tick();
    chk("t3_no_repulse", done_pulses - d0, 32'd1);

    // Test 4: bit 0 of field flipped
    d0 = done_pulses;
    run_frame(32'hB1C1BDE3);
    repeat (3) tick();
    chk("t4_err", {30'd0, crc_ok, crc_err}, 32'h1);
    chk("t4_pulses", done_pulses - d0, 32'd1);

    // Success while in CMP suppresses crc_done
    d0 = done_pulses;
    run_frame(32'hB1C1BDE2);
    rx_success = 1'b1;
    tick();
    rx_success = 1'b0;
    repeat (2) tick();
    chk("cmp_succ_pulses", done_pulses - d0, 32'd0);
    chk("cmp_succ_flags", {29'd0, crc_ok, crc_err, busy}, 32'h0);
    chk("cmp_succ_val", crc_val, 32'h0);

    // Test 5: both enables -> field capture wins; CRC frozen
    do_init();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    chk("t5_both_rcvd", crc_rcvd, 32'h1);
    chk("t5_both_val", crc_val, 32'h90BF6B5E);
    // initialize with a strobe: clear wins, bit dropped
    initialize = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    initialize = 1'b0;
    chk("t5_init_val", crc_val, 32'h0);
    chk("t5_init_rcvd", crc_rcvd, 32'h0);
    // tx_success mid-frame returns to IDLE
    send_bit(1'b1, 1'b1, 1'b0);
    tx_success = 1'b1;
    tick();
    tx_success = 1'b0;
    chk("t5_tx_clear", {crc_val[30:0], busy}, 32'h0);

    // Test 6: asynchronous reset mid-field
    do_init();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    snap = crc_rcvd;
    chk("t6_pre_rcvd", snap, 32'h2);
    #3 g_rst = 1'b1;
    #1;
    chk("t6_async_val", crc_val, 32'h0);
    chk("t6_async_rcvd", crc_rcvd, 32'h0);
    chk("t6_async_busy", {31'd0, busy}, 32'h0);
    tick();
    g_rst = 1'b0;
    tick();

    // 15-bit instance: one data bit 1 gives the polynomial
    do_init();
    send_bit(1'b1, 1'b1, 1'b0);
    chk("t6_w15_val", {17'd0, s_crc_val}, 32'h4599);
    chk("t6_w15_busy", {31'd0, s_busy}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
